// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: execution-unit result requests in, single ROB writeback port out.
// rob_head exists only when WB_ARB_OLDEST_FIRST_EN is defined.
interface wb_arbiter_if #(
   parameter int REQ  = 4,
   parameter int DATA = 32,
   parameter int ROB  = 4,
   parameter int EXP  = 4
);
   logic                      flush_;
   logic [REQ-1:0]            req_e_;
   logic [REQ-1:0][ROB-1:0]   req_rd;
   logic [REQ-1:0][DATA-1:0]  req_data;
   logic [REQ-1:0]            req_exp_;
   logic [REQ-1:0][EXP-1:0]   req_exp_code;
   logic [REQ-1:0]            req_pred_miss_;
   logic [REQ-1:0]            req_jump_miss_;
   logic [REQ-1:0]            req_stall_;
   logic                      wb_e_;
   logic [ROB-1:0]            wb_rd;
   logic [DATA-1:0]           wb_data;
   logic                      wb_exp_;
   logic [EXP-1:0]            wb_exp_code;
   logic                      wb_pred_miss_;
   logic                      wb_jump_miss_;
`ifdef WB_ARB_OLDEST_FIRST_EN
   logic [ROB-1:0]            rob_head;
   modport slave (
      input  flush_, req_e_, req_rd, req_data, req_exp_, req_exp_code, req_pred_miss_, req_jump_miss_, rob_head,
      output req_stall_, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_
   );
   modport master (
      output flush_, req_e_, req_rd, req_data, req_exp_, req_exp_code, req_pred_miss_, req_jump_miss_, rob_head,
      input  req_stall_, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_
   );
`else
   modport slave (
      input  flush_, req_e_, req_rd, req_data, req_exp_, req_exp_code, req_pred_miss_, req_jump_miss_,
      output req_stall_, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_
   );
   modport master (
      output flush_, req_e_, req_rd, req_data, req_exp_, req_exp_code, req_pred_miss_, req_jump_miss_,
      input  req_stall_, wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_
   );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: one holding slot per execution unit, round-robin onto the ROB writeback port.
// Define WB_ARB_OLDEST_FIRST_EN to grant the slot whose ROB id is nearest rob_head.
module wb_arbiter #(
   parameter int DATA      = 32,
   parameter int ROB_DEPTH = 16,
   parameter int ROB       = $clog2(ROB_DEPTH),
   parameter int REQ       = 4,
   parameter int EXP       = 4
) (
   input logic         clk,
   input logic         reset_,
   wb_arbiter_if.slave bus
);
   localparam int PW = REQ > 1 ? $clog2(REQ) : 1;
   logic [REQ-1:0]           vld, exp_q, pm_q, jm_q, stall, acc;
   logic [REQ-1:0][ROB-1:0]  rd_q;
   logic [REQ-1:0][DATA-1:0] data_q;
   logic [REQ-1:0][EXP-1:0]  code_q;
   logic [PW-1:0]            rr_ptr, gnt, idx;
   logic                     gnt_v, act;
`ifdef WB_ARB_OLDEST_FIRST_EN
   int                       dist, best;
`endif
   // scan starts at rr_ptr so the ring order doubles as the tie-breaker
   always_comb begin
      gnt   = rr_ptr;
      gnt_v = 1'b0;
      idx   = rr_ptr;
`ifdef WB_ARB_OLDEST_FIRST_EN
      dist  = 0;
      best  = 0;
      for (int k = 0; k < REQ; k++) begin
         idx  = PW'((int'(rr_ptr) + k) % REQ);
         dist = (int'(rd_q[idx]) - int'(bus.rob_head) + ROB_DEPTH) % ROB_DEPTH;
         if (vld[idx] && (!gnt_v || dist < best)) begin
            gnt   = idx;
            gnt_v = 1'b1;
            best  = dist;
         end
      end
`else
      for (int k = 0; k < REQ; k++) begin
         idx = PW'((int'(rr_ptr) + k) % REQ);
         if (vld[idx] && !gnt_v) begin
            gnt   = idx;
            gnt_v = 1'b1;
         end
      end
`endif
   end
   assign act = gnt_v & bus.flush_;
   always_comb begin
      stall = '1;
      for (int i = 0; i < REQ; i++)
         stall[i] = ~(vld[i] & bus.flush_ & ~(act & (gnt == PW'(i))));
   end
   assign acc                = ~bus.req_e_ & stall;
   assign bus.req_stall_     = stall;
   assign bus.wb_e_          = ~act;
   assign bus.wb_rd          = act ? rd_q[gnt]   : '0;
   assign bus.wb_data        = act ? data_q[gnt] : '0;
   assign bus.wb_exp_code    = act ? code_q[gnt] : '0;
   assign bus.wb_exp_        = act ? exp_q[gnt]  : 1'b1;
   assign bus.wb_pred_miss_  = act ? pm_q[gnt]   : 1'b1;
   assign bus.wb_jump_miss_  = act ? jm_q[gnt]   : 1'b1;
   // a granted slot refills in the same edge so a streaming requester sees no bubble
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         vld    <= '0;
         rr_ptr <= '0;
         rd_q   <= '0;
         data_q <= '0;
         code_q <= '0;
         exp_q  <= '1;
         pm_q   <= '1;
         jm_q   <= '1;
      end else if (!bus.flush_) begin
         vld <= '0;
      end else begin
         if (act) rr_ptr <= PW'((int'(gnt) + 1) % REQ);
         for (int i = 0; i < REQ; i++) begin
            if (acc[i]) begin
               vld[i]    <= 1'b1;
               rd_q[i]   <= bus.req_rd[i];
               data_q[i] <= bus.req_data[i];
               code_q[i] <= bus.req_exp_code[i];
               exp_q[i]  <= bus.req_exp_[i];
               pm_q[i]   <= bus.req_pred_miss_[i];
               jm_q[i]   <= bus.req_jump_miss_[i];
            end else if (act && gnt == PW'(i)) begin
               vld[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, reset/flush/oldest-first sequences, then random traffic vs a reference model.
module tb_wb_arbiter;
   localparam int REQ = 4, DATA = 32, ROB_DEPTH = 16, ROB = 4, EXP = 4, NV = 21;
   localparam logic [EXP-1:0] EXP_I_MISS_ALIGN = 4'h8;

   typedef struct packed {
      logic [3:0]  e_;
      logic        flush_;
      logic [3:0]  ex_;
      logic [3:0]  pm_;
      logic [3:0]  rd;
      logic [31:0] db;
      logic        x_e_;
      logic [3:0]  x_rd;
      logic [31:0] x_data;
      logic [3:0]  x_code;
      logic        x_ex_;
      logic        x_pm_;
      logic [3:0]  x_stall_;
   } vec_t;

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   int   checks = 0;
   int   failures = 0;
   vec_t tbl [NV];

   logic [REQ-1:0]  m_v, m_ex, m_pm, m_jm;
   logic [ROB-1:0]  m_rd   [REQ];
   logic [DATA-1:0] m_data [REQ];
   logic [EXP-1:0]  m_code [REQ];
   int              m_ptr;

   wb_arbiter_if #(.REQ(REQ), .DATA(DATA), .ROB(ROB), .EXP(EXP)) bus ();
   wb_arbiter #(.DATA(DATA), .ROB_DEPTH(ROB_DEPTH), .ROB(ROB), .REQ(REQ), .EXP(EXP))
      dut (.clk(clk), .reset_(reset_), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [EXP-1:0] code_of(input int i);
      return i == 0 ? EXP_I_MISS_ALIGN : EXP'(i);
   endfunction

   task automatic idle();
      bus.flush_         = 1'b1;
      bus.req_e_         = '1;
      bus.req_exp_       = '1;
      bus.req_pred_miss_ = '1;
      bus.req_jump_miss_ = '1;
      bus.req_rd         = '0;
      bus.req_data       = '0;
      bus.req_exp_code   = '0;
`ifdef WB_ARB_OLDEST_FIRST_EN
      bus.rob_head       = '0;
`endif
   endtask

   task automatic do_reset();
      idle();
      reset_ = 1'b0;
      repeat (2) @(negedge clk);
      reset_ = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // reference: first valid slot in ring order from the pointer (or nearest to rob_head)
   function automatic int pick();
      int g, best, d, i;
      g = -1;
      best = 0;
      for (int k = 0; k < REQ; k++) begin
         i = (m_ptr + k) % REQ;
`ifdef WB_ARB_OLDEST_FIRST_EN
         d = (int'(m_rd[i]) - int'(bus.rob_head) + ROB_DEPTH) % ROB_DEPTH;
`else
         d = k;
`endif
         if (m_v[i] && (g < 0 || d < best)) begin
            g = i;
            best = d;
         end
      end
      return g;
   endfunction

   initial begin
      tbl[0]  = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[1]  = '{4'h0, 1'b1, 4'hf, 4'hf, 4'd0, 32'h100,  1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[2]  = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd0,  32'h100,  4'h8, 1'b1, 1'b1, 4'b0001};
      tbl[3]  = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd1,  32'h101,  4'h1, 1'b1, 1'b1, 4'b0011};
      tbl[4]  = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd2,  32'h102,  4'h2, 1'b1, 1'b1, 4'b0111};
      tbl[5]  = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd3,  32'h103,  4'h3, 1'b1, 1'b1, 4'hf};
      tbl[6]  = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[7]  = '{4'hb, 1'b1, 4'hf, 4'hf, 4'd3, 32'haaa8, 1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[8]  = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd5,  32'haaaa, 4'h2, 1'b1, 1'b1, 4'hf};
      tbl[9]  = '{4'hd, 1'b1, 4'hf, 4'hf, 4'd3, 32'h200,  1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[10] = '{4'hd, 1'b1, 4'hf, 4'hf, 4'd4, 32'h300,  1'b0, 4'd4,  32'h201,  4'h1, 1'b1, 1'b1, 4'hf};
      tbl[11] = '{4'hd, 1'b1, 4'hf, 4'hf, 4'd5, 32'h400,  1'b0, 4'd5,  32'h301,  4'h1, 1'b1, 1'b1, 4'hf};
      tbl[12] = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd6,  32'h401,  4'h1, 1'b1, 1'b1, 4'hf};
      tbl[13] = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[14] = '{4'ha, 1'b1, 4'hf, 4'hf, 4'd8, 32'h500,  1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[15] = '{4'h7, 1'b0, 4'hf, 4'hf, 4'd6, 32'h600,  1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[16] = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[17] = '{4'hc, 1'b1, 4'he, 4'hd, 4'd10, 32'h700, 1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};
      tbl[18] = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd10, 32'h700,  4'h8, 1'b0, 1'b1, 4'b1101};
      tbl[19] = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b0, 4'd11, 32'h701,  4'h1, 1'b1, 1'b0, 4'hf};
      tbl[20] = '{4'hf, 1'b1, 4'hf, 4'hf, 4'd0, 32'h0,    1'b1, 4'd0,  32'h0,    4'h0, 1'b1, 1'b1, 4'hf};

      do_reset();
      for (int r = 0; r < NV; r++) begin
         bus.req_e_         = tbl[r].e_;
         bus.flush_         = tbl[r].flush_;
         bus.req_exp_       = tbl[r].ex_;
         bus.req_pred_miss_ = tbl[r].pm_;
         bus.req_jump_miss_ = '1;
         for (int i = 0; i < REQ; i++) begin
            bus.req_rd[i]       = tbl[r].rd + ROB'(i);
            bus.req_data[i]     = tbl[r].db + DATA'(i);
            bus.req_exp_code[i] = code_of(i);
         end
         #1;
         chk($sformatf("v%0d wb_e_", r), 32'(bus.wb_e_), 32'(tbl[r].x_e_));
         chk($sformatf("v%0d wb_rd", r), 32'(bus.wb_rd), 32'(tbl[r].x_rd));
         chk($sformatf("v%0d wb_data", r), bus.wb_data, tbl[r].x_data);
         chk($sformatf("v%0d wb_exp_code", r), 32'(bus.wb_exp_code), 32'(tbl[r].x_code));
         chk($sformatf("v%0d wb_exp_", r), 32'(bus.wb_exp_), 32'(tbl[r].x_ex_));
         chk($sformatf("v%0d wb_pred_miss_", r), 32'(bus.wb_pred_miss_), 32'(tbl[r].x_pm_));
         chk($sformatf("v%0d req_stall_", r), 32'(bus.req_stall_), 32'(tbl[r].x_stall_));
         step();
      end

      // asynchronous reset with results pending: slots 1 and 3, pointer at 2
      idle();
      bus.req_e_ = 4'b0101;
      for (int i = 0; i < REQ; i++) begin
         bus.req_rd[i]   = ROB'(i);
         bus.req_data[i] = 32'h800 + DATA'(i);
      end
      step();
      idle();
      #1;
      chk("pre_rst wb_e_", 32'(bus.wb_e_), 32'h0);
      chk("pre_rst wb_data", bus.wb_data, 32'h803);
      #2 reset_ = 1'b0;
      #1;
      chk("in_rst wb_e_", 32'(bus.wb_e_), 32'h1);
      chk("in_rst wb_data", bus.wb_data, 32'h0);
      chk("in_rst req_stall_", 32'(bus.req_stall_), 32'hf);
      @(negedge clk);
      reset_ = 1'b1;
      #1;
      chk("post_rst wb_e_", 32'(bus.wb_e_), 32'h1);
      step();

`ifdef WB_ARB_OLDEST_FIRST_EN
      do_reset();
      bus.rob_head = 4'd14;
      bus.req_e_ = 4'b1000;
      bus.req_rd[0] = 4'd1;
      bus.req_rd[1] = 4'd15;
      bus.req_rd[2] = 4'd14;
      step();
      bus.req_e_ = '1;
      #1;
      chk("old0 wb_rd", 32'(bus.wb_rd), 32'd14);
      step();
      #1;
      chk("old1 wb_rd", 32'(bus.wb_rd), 32'd15);
      #1 reset_ = 1'b0;
      #1;
      chk("old_rst wb_e_", 32'(bus.wb_e_), 32'h1);
      @(negedge clk);
      reset_ = 1'b1;
`endif

      do_reset();
      m_v = '0;
      m_ptr = 0;
      for (int n = 0; n < 2000; n++) begin
         int g, gi;
         logic a;
         logic [REQ-1:0] st;
         bus.flush_         = $urandom_range(15) != 0;
         bus.req_e_         = REQ'($urandom);
         bus.req_exp_       = REQ'($urandom);
         bus.req_pred_miss_ = REQ'($urandom);
         bus.req_jump_miss_ = REQ'($urandom);
         for (int i = 0; i < REQ; i++) begin
            bus.req_rd[i]       = ROB'($urandom);
            bus.req_data[i]     = $urandom;
            bus.req_exp_code[i] = EXP'($urandom);
         end
`ifdef WB_ARB_OLDEST_FIRST_EN
         bus.rob_head = ROB'($urandom);
`endif
         #1;
         g = pick();
         gi = g < 0 ? 0 : g;
         a = g >= 0 && bus.flush_;
         for (int i = 0; i < REQ; i++) st[i] = !(m_v[i] && bus.flush_ && !(a && g == i));
         chk("rnd wb_e_", 32'(bus.wb_e_), 32'(!a));
         chk("rnd wb_rd", 32'(bus.wb_rd), a ? 32'(m_rd[gi]) : 32'h0);
         chk("rnd wb_data", bus.wb_data, a ? m_data[gi] : 32'h0);
         chk("rnd wb_exp_code", 32'(bus.wb_exp_code), a ? 32'(m_code[gi]) : 32'h0);
         chk("rnd flags", {29'h0, bus.wb_exp_, bus.wb_pred_miss_, bus.wb_jump_miss_},
             a ? {29'h0, m_ex[gi], m_pm[gi], m_jm[gi]} : 32'h7);
         chk("rnd req_stall_", 32'(bus.req_stall_), 32'(st));
         @(posedge clk);
         if (!bus.flush_) m_v = '0;
         else begin
            if (g >= 0) begin
               m_v[g] = 1'b0;
               m_ptr = (g + 1) % REQ;
            end
            for (int i = 0; i < REQ; i++)
               if (!bus.req_e_[i] && st[i]) begin
                  m_v[i]    = 1'b1;
                  m_rd[i]   = bus.req_rd[i];
                  m_data[i] = bus.req_data[i];
                  m_code[i] = bus.req_exp_code[i];
                  m_ex[i]   = bus.req_exp_[i];
                  m_pm[i]   = bus.req_pred_miss_[i];
                  m_jm[i]   = bus.req_jump_miss_[i];
               end
         end
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single reorder-buffer writeback port (wb_e_, wb_rd, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_) among REQ execution units.
- Each requester has a one-entry holding slot. A round-robin arbiter picks one valid slot per cycle and drives it onto the writeback port.
- Sits between the execution units and reorder_buffer. Pending results are discarded on a ROB flush.

Parameters:
- DATA, `DataWidth, writeback data width.
- ROB_DEPTH, `RobDepth, reorder buffer entries.
- ROB, $clog2(ROB_DEPTH), ROB id width (derived).
- REQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- flush_  in  1  active-low; ROB pipeline flush.
- req_e_  in  REQ  active-low per-requester result valid.
- req_rd  in  RegFile_t x REQ  destination (addr = ROB id) per requester.
- req_data  in  DATA x REQ  result data.
- req_exp_  in  REQ  active-low exception flag.
- req_exp_code  in  ExpCode_t x REQ  exception code.
- req_pred_miss_  in  REQ  active-low branch mispredict.
- req_jump_miss_  in  REQ  active-low jump target miss.
- req_stall_  out  REQ  active-low; requester must hold its result.
- wb_e_  out  1  active-low writeback valid to ROB.
- wb_rd  out  RegFile_t  granted destination.
- wb_data  out  DATA  granted data.
- wb_exp_  out  1  granted exception flag.
- wb_exp_code  out  ExpCode_t  granted exception code.
- wb_pred_miss_  out  1  granted mispredict flag.
- wb_jump_miss_  out  1  granted jump-miss flag.

Behaviour:
- State:
  - Per-requester slot: valid bit plus all request fields.
  - Round-robin pointer rr_ptr, width $clog2(REQ).
- Reset (async, reset_ low):
  - All slots invalid; rr_ptr = 0.
  - req_stall_ all Disable_.
  - wb_e_, wb_exp_, wb_pred_miss_, wb_jump_miss_ = Disable_.
  - wb_rd = 0, wb_data = 0, wb_exp_code = 0.
  - Reset mid-operation discards all held results.
- Accept: slot i captures the request at the edge when req_e_[i] == Enable_ and req_stall_[i] == Disable_. A request presented while stalled is ignored; the requester holds it.
- Grant (combinational from slot state):
  - Search valid slots starting at rr_ptr, ascending, wrapping modulo REQ.
  - The first valid slot found is granted.
  - Unused encodings when REQ is not a power of two are skipped.
- Writeback outputs:
  - Driven combinationally from the granted slot; wb_e_ = Enable_ iff any slot is valid and flush_ == Disable_.
  - With no grant, outputs hold their reset values.
  - Latency: request accepted at edge N produces wb_e_ in cycle N+1 if uncontended.
- Granted slot at the edge: cleared unless its requester presents a new accepted request the same cycle, in which case it is refilled (back-to-back, no bubble). rr_ptr <= granted index + 1 mod REQ.
- No grant: rr_ptr unchanged.
- Stall: req_stall_[i] = Enable_ iff slot i valid and not granted this cycle.
- Flush: while flush_ == Enable_:
  - wb_e_ forced Disable_.
  - All slots cleared at the edge; requests presented in that cycle are dropped.
  - req_stall_ forced Disable_.
  - rr_ptr unchanged.
- Fairness: a valid slot is granted within REQ cycles.

Optional Feature:
- Macro WB_ARB_OLDEST_FIRST_EN. Defined:
  - Adds input rob_head [ROB-1:0], the ROB commit head id.
  - Grant goes to the valid slot with the smallest (req_rd.addr - rob_head) mod ROB_DEPTH.
  - rr_ptr still updates and breaks ties, which only arise from illegal duplicate ids.
- Undefined: port absent; pure round-robin as above.

Test Plan:
- Single request: req_e_[2]=Enable_, rd.addr=5, data=0xaaaa at cycle 1 -> cycle 2: wb_e_=Enable_, wb_rd.addr=5, wb_data=0xaaaa, req_stall_ all Disable_.
- All 4 request together, ids 0..3, rr_ptr=0:
  - Grants in cycles 2,3,4,5 in order 0,1,2,3.
  - req_stall_[3] Enable_ in cycles 2..4.
  - rr_ptr=0 afterward.
- Requester 1 issues every cycle alone (ids 4,5,6) -> wb_e_ continuous for 3 cycles, ids 4,5,6, no stall.
- Slots 0,2 valid, flush_=Enable_ for one cycle with new req_e_[3] -> no wb_e_ that cycle; next cycle all slots empty, wb_e_=Disable_.
- Flags: req_pred_miss_[1]=Enable_ and req_exp_[0]=Enable_ with exp_code=EXP_I_MISS_ALIGN -> each flag appears only in its own granted cycle.
- WB_ARB_OLDEST_FIRST_EN, rob_head=14, slot ids {1,15,14} -> grant order 14, 15, 1; reset asserted mid-sequence -> wb_e_ Disable_ immediately.
